branch_resolve: RTL
===================

// Module: branch_resolve
// PURPOSE
//  Execute-stage branch resolution unit sitting directly downstream of the ALU.
//  Consumes ALU SUB flags (zero/negative/carry/over_flow) for a branch or jump,
//  decides taken/not-taken, computes target = pc + imm, and drives a held
//  redirect to fetch followed by a counted flush of younger pipeline slots.
// PARAMETERS
//  WIDTH         32  datapath / PC width in bits
//  FLUSH_CYCLES  2   cycles flush is asserted after redirect_ack (0..15)
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      asynchronous, active-high reset
//  in_valid        in   1      branch/jump descriptor valid
//  in_ready        out  1      unit can accept a descriptor
//  in_branch       in   1      conditional branch
//  in_jump         in   1      unconditional jump (jal/jalr); wins over in_branch
//  in_funct3       in   3      branch condition select
//  in_pc           in   WIDTH  PC of branch instruction
//  in_imm          in   WIDTH  sign-extended offset
//  alu_zero        in   1      ALU result == 0 (a == b)
//  alu_negative    in   1      ALU result MSB
//  alu_carry       in   1      SUB carry-out (1 => a >= b unsigned)
//  alu_over_flow   in   1      SUB signed overflow
//  redirect_valid  out  1      redirect request to fetch
//  redirect_pc     out  WIDTH  redirect target
//  redirect_ack    in   1      fetch accepted redirect
//  flush           out  1      kill younger instructions
//  resolved        out  1      1-cycle pulse: descriptor resolved
//  taken           out  1      qualifies resolved: branch taken
//  misalign_err    out  1      1-cycle pulse: taken target[1:0] != 0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; in_ready=1; redirect_valid, flush,
//    resolved, taken, misalign_err=0; redirect_pc=0; flush counter=0.
//  - Accept on in_valid & in_ready; in_ready = (state==IDLE). Flags sampled same cycle.
//  - Conditions: 000 BEQ zero; 001 BNE ~zero; 100 BLT N^V; 101 BGE ~(N^V);
//    110 BLTU ~C; 111 BGEU C; 010/011 never taken. in_jump => taken regardless.
//  - Neither in_branch nor in_jump: accepted, resolved=1, taken=0, no redirect.
//  - Target = in_pc + in_imm, modulo 2^WIDTH (wrap-around, no error).
//  - Latency: resolved/taken registered, asserted the cycle after accept.
//  - Taken & target[1:0]!=0: misalign_err=1 with resolved, no redirect, stay IDLE.
//  - FSM IDLE -> REDIRECT (taken, aligned): redirect_valid=1, redirect_pc=target,
//    both held stable until redirect_ack; flush=0 in REDIRECT.
//  - REDIRECT & redirect_ack -> FLUSH (counter=FLUSH_CYCLES), or IDLE if FLUSH_CYCLES==0.
//    redirect_valid drops the cycle after ack.
//  - FLUSH: flush=1 each cycle, counter decrements; counter==1 -> IDLE next edge.
//  - redirect_ack outside REDIRECT ignored. in_valid outside IDLE not accepted.
//  - Ack in first REDIRECT cycle legal: REDIRECT lasts exactly one cycle.
// CONFIGURATION
//  BRANCH_STATS_EN defined: adds outputs taken_cnt[31:0], not_taken_cnt[31:0];
//   increment on each resolved pulse (misaligned counts as taken); saturate at
//   32'hFFFF_FFFF; reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  riscv_pkg: BR_BEQ..BR_BGEU funct3 localparams, br_state_t enum
//   {BR_IDLE, BR_REDIRECT, BR_FLUSH}.
//  Sub-module branch_cond: combinational funct3 + flags -> cond_true.
//  Top holds FSM, target adder, flush counter, optional stats.
// TESTING
//  1 BEQ, zero=1, pc=0x100, imm=0x20 -> next cycle resolved=1,taken=1;
//    redirect_pc=0x120 held until ack; then flush=1 exactly 2 cycles.
//  2 BLT, N=1,V=1 -> taken=0, no redirect, in_ready stays 1.
//  3 BGEU C=1 with pc=0xFFFF_FFF0, imm=0x20 -> redirect_pc=0x0000_0010.
//  4 jal imm=0x6 -> misalign_err=1, taken=1, redirect_valid=0.
//  5 Hold redirect_ack=0 for 5 cycles -> redirect_valid/pc stable, in_ready=0,
//    in_valid ignored; then ack -> FLUSH.
//  6 Assert rst during FLUSH -> immediately flush=0, in_ready=1; BRANCH_STATS_EN
//    build: counters read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the execute-stage branch resolution unit:
// branch condition encodings (funct3) and the resolver FSM state type.
package riscv_pkg;

  // Branch condition select encodings (funct3 field)
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // Resolver FSM states
  typedef enum logic [1:0] {
    BR_IDLE     = 2'd0,
    BR_REDIRECT = 2'd1,
    BR_FLUSH    = 2'd2
  } br_state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps funct3 plus the ALU SUB flags to a
// single "condition true" bit. Purely combinational. The encodings
// 010/011 are not branch conditions and always evaluate false.
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_negative,
  input  logic       i_carry,
  input  logic       i_over_flow,
  output logic       o_cond_true
);

  logic w_lt_signed;

  // Signed less-than after a SUB is N xor V.
  assign w_lt_signed = i_negative ^ i_over_flow;

  // Select the condition; carry set means a >= b unsigned.
  always_comb begin
    o_cond_true = 1'b0;
    case (i_funct3)
      BR_BEQ:  o_cond_true = i_zero;
      BR_BNE:  o_cond_true = ~i_zero;
      BR_BLT:  o_cond_true = w_lt_signed;
      BR_BGE:  o_cond_true = ~w_lt_signed;
      BR_BLTU: o_cond_true = ~i_carry;
      BR_BGEU: o_cond_true = i_carry;
      default: o_cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution unit. Decides taken/not-taken from the
// ALU SUB flags, computes target = pc + imm (wrapping), holds a redirect
// to fetch until acknowledged, then asserts flush for FLUSH_CYCLES cycles.
// Optional feature macro: BRANCH_STATS_EN adds saturating taken /
// not-taken counters (taken_cnt, not_taken_cnt).
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_branch,
  input  logic             in_jump,
  input  logic [2:0]       in_funct3,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_carry,
  input  logic             alu_over_flow,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  input  logic             redirect_ack,
  output logic             flush,
  output logic             resolved,
  output logic             taken,
  output logic             misalign_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      taken_cnt,
  output logic [31:0]      not_taken_cnt
`endif
);

  localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_CYCLES);

  br_state_t        r_state;
  br_state_t        w_state_nxt;
  logic [3:0]       r_flush_cnt;
  logic [3:0]       w_flush_cnt_nxt;
  logic             r_redirect_valid;
  logic [WIDTH-1:0] r_redirect_pc;
  logic             r_flush;
  logic             r_resolved;
  logic             r_taken;
  logic             r_misalign;

  logic             w_accept;
  logic             w_cond_true;
  logic             w_taken;
  logic [WIDTH-1:0] w_target;
  logic             w_misalign;
  logic             w_load_pc;

  branch_cond u_cond (
    .i_funct3    (in_funct3),
    .i_zero      (alu_zero),
    .i_negative  (alu_negative),
    .i_carry     (alu_carry),
    .i_over_flow (alu_over_flow),
    .o_cond_true (w_cond_true)
  );

  assign in_ready   = (r_state == BR_IDLE);
  assign w_accept   = in_valid & in_ready;
  // Jump wins over branch; a descriptor that is neither is never taken.
  assign w_taken    = in_jump | (in_branch & w_cond_true);
  assign w_target   = in_pc + in_imm;
  assign w_misalign = w_taken & (w_target[1:0] != 2'b00);

  // FSM state and flush counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= BR_IDLE;
      r_flush_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Next-state, counter and redirect-target load decisions.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_load_pc       = 1'b0;
    case (r_state)
      BR_IDLE: begin
        if (w_accept && w_taken && !w_misalign) begin
          w_state_nxt = BR_REDIRECT;
          w_load_pc   = 1'b1;
        end else begin
          w_state_nxt = BR_IDLE;
        end
      end
      BR_REDIRECT: begin
        if (redirect_ack) begin
          if (FLUSH_CNT == 4'd0) begin
            w_state_nxt = BR_IDLE;
          end else begin
            w_state_nxt     = BR_FLUSH;
            w_flush_cnt_nxt = FLUSH_CNT;
          end
        end else begin
          w_state_nxt = BR_REDIRECT;
        end
      end
      BR_FLUSH: begin
        w_flush_cnt_nxt = r_flush_cnt - 4'd1;
        if (r_flush_cnt <= 4'd1) begin
          w_state_nxt = BR_IDLE;
        end else begin
          w_state_nxt = BR_FLUSH;
        end
      end
      default: begin
        w_state_nxt     = BR_IDLE;
        w_flush_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Registered outputs: derived from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_resolved       <= 1'b0;
      r_taken          <= 1'b0;
      r_misalign       <= 1'b0;
    end else begin
      r_redirect_valid <= (w_state_nxt == BR_REDIRECT);
      r_flush          <= (w_state_nxt == BR_FLUSH);
      r_resolved       <= w_accept;
      r_taken          <= w_accept & w_taken;
      r_misalign       <= w_accept & w_misalign;
      if (w_load_pc) begin
        r_redirect_pc <= w_target;
      end
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = r_flush;
  assign resolved       = r_resolved;
  assign taken          = r_taken;
  assign misalign_err   = r_misalign;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_taken_cnt;
  logic [31:0] r_not_taken_cnt;

  // Saturating statistics; updated on the same edge that raises resolved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_cnt     <= 32'd0;
      r_not_taken_cnt <= 32'd0;
    end else if (w_accept) begin
      if (w_taken) begin
        if (r_taken_cnt != 32'hFFFF_FFFF) r_taken_cnt <= r_taken_cnt + 32'd1;
      end else begin
        if (r_not_taken_cnt != 32'hFFFF_FFFF) r_not_taken_cnt <= r_not_taken_cnt + 32'd1;
      end
    end
  end

  assign taken_cnt     = r_taken_cnt;
  assign not_taken_cnt = r_not_taken_cnt;
`endif

endmodule
